// File: rtl/mkmif_arb_if.sv
// mkmif_arb_if: requester ports A/B and the mkmif_core command/status bundle.
// The arbiter connects through the slave modport; requesters and core use master.
interface mkmif_arb_if;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic              a_err;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic              b_err;
    logic [DATA_W-1:0] b_rdata;

    logic              core_write_op;
    logic              core_read_op;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_write_data;
    logic              core_ready;
    logic              core_valid;
    logic [DATA_W-1:0] core_read_data;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_err, b_rdata,
        output core_write_op, core_read_op, core_addr, core_write_data,
        input  core_ready, core_valid, core_read_data
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_err, b_rdata,
        input  core_write_op, core_read_op, core_addr, core_write_data,
        output core_ready, core_valid, core_read_data
    );
endinterface

// File: rtl/mkmif_arb.sv
// mkmif_arb: two-port round-robin arbiter and transaction sequencer for mkmif_core.
// Define MKMIF_ARB_TIMEOUT_EN to add a per-transaction watchdog of TIMEOUT_CYCLES clocks.
module mkmif_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    mkmif_arb_if.slave bus
);
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ISSUE      = 3'd1;
    localparam logic [2:0] WAIT_START = 3'd2;
    localparam logic [2:0] WAIT_DONE  = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              last_grant;
    logic              cur_port;
    logic              cur_we;

    logic              win_port_c;
    logic              win_we_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [DATA_W-1:0] win_wdata_c;
    logic              grant_c;
    logic              finish_c;
    logic              fail_c;
    logic              capture_c;
    logic              tmo_hit_c;
    logic              tmo_block_c;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        win_port_c = PORT_A;
        if (bus.a_req && bus.b_req) begin
            win_port_c = ~last_grant;
        end else if (bus.b_req) begin
            win_port_c = PORT_B;
        end
        win_we_c    = (win_port_c == PORT_B) ? bus.b_we    : bus.a_we;
        win_addr_c  = (win_port_c == PORT_B) ? bus.b_addr  : bus.a_addr;
        win_wdata_c = (win_port_c == PORT_B) ? bus.b_wdata : bus.a_wdata;
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        state_next = state;
        grant_c    = 1'b0;
        finish_c   = 1'b0;
        fail_c     = 1'b0;
        capture_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.core_ready && !tmo_block_c && (bus.a_req || bus.b_req)) begin
                    grant_c    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (tmo_hit_c) begin
                    finish_c   = 1'b1;
                    fail_c     = 1'b1;
                    state_next = DONE;
                end else if (!bus.core_ready) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.core_ready) begin
                    finish_c   = 1'b1;
                    fail_c     = !cur_we && !bus.core_valid;
                    capture_c  = !cur_we;
                    state_next = DONE;
                end else if (tmo_hit_c) begin
                    finish_c   = 1'b1;
                    fail_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched transaction fields and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            last_grant          <= PORT_B;
            cur_port            <= PORT_A;
            cur_we              <= 1'b0;
            bus.a_ack           <= 1'b0;
            bus.b_ack           <= 1'b0;
            bus.a_err           <= 1'b0;
            bus.b_err           <= 1'b0;
            bus.a_rdata         <= '0;
            bus.b_rdata         <= '0;
            bus.core_write_op   <= 1'b0;
            bus.core_read_op    <= 1'b0;
            bus.core_addr       <= '0;
            bus.core_write_data <= '0;
        end else begin
            state             <= state_next;
            bus.core_write_op <= grant_c && win_we_c;
            bus.core_read_op  <= grant_c && !win_we_c;
            bus.a_ack         <= finish_c && (cur_port == PORT_A);
            bus.b_ack         <= finish_c && (cur_port == PORT_B);
            bus.a_err         <= fail_c && (cur_port == PORT_A);
            bus.b_err         <= fail_c && (cur_port == PORT_B);
            if (grant_c) begin
                cur_port            <= win_port_c;
                cur_we              <= win_we_c;
                bus.core_addr       <= win_addr_c;
                bus.core_write_data <= win_wdata_c;
            end
            if (capture_c && (cur_port == PORT_A)) begin
                bus.a_rdata <= bus.core_read_data;
            end
            if (capture_c && (cur_port == PORT_B)) begin
                bus.b_rdata <= bus.core_read_data;
            end
            if (state == DONE) begin
                last_grant <= cur_port;
            end
        end
    end

`ifdef MKMIF_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_block;
    logic             tmo_fire_c;

    // Fires on the edge where the wait count would reach TIMEOUT_CYCLES.
    assign tmo_hit_c   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_fire_c  = tmo_hit_c &&
                         ((state == WAIT_START) || ((state == WAIT_DONE) && !bus.core_ready));
    assign tmo_block_c = tmo_block;

    // After an abandoned command, hold off granting until the core reports ready in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt   <= '0;
            tmo_block <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if ((state == WAIT_START) || (state == WAIT_DONE)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (tmo_fire_c) begin
                tmo_block <= 1'b1;
            end else if ((state == IDLE) && bus.core_ready) begin
                tmo_block <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit_c      = 1'b0;
    assign tmo_block_c    = 1'b0;
    assign unused_timeout = ^CNT_W'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_mkmif_arb.sv
// tb_mkmif_arb: directed and randomized bench for mkmif_arb with an in-bench core model.
// Define MKMIF_ARB_TIMEOUT_EN for both RTL and bench to also cover the watchdog.
module tb_mkmif_arb;
    localparam int unsigned TMO = 20;

    logic clk = 1'b0;
    logic reset;

    mkmif_arb_if bus ();

    mkmif_arb #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          valid;
    } op_t;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    // Core model: each command drops ready for cm_delay cycles, then returns a result.
    int          cm_delay = 1;
    bit          cm_rand  = 1'b1;
    logic [31:0] cm_data  = 32'h0;
    bit          cm_valid = 1'b1;
    bit          hold_low = 1'b0;
    logic        cm_ready;
    int          cm_cnt;
    op_t         pend;
    op_t         op_q[$];

    assign bus.core_ready = cm_ready & ~hold_low;

    always @(posedge clk) begin
        if (reset) begin
            cm_ready           <= 1'b1;
            cm_cnt             <= 0;
            bus.core_valid     <= 1'b0;
            bus.core_read_data <= 32'h0;
        end else if (bus.core_read_op || bus.core_write_op) begin
            op_t o;
            o.we    = bus.core_write_op;
            o.addr  = bus.core_addr;
            o.wdata = bus.core_write_data;
            o.rdata = cm_rand ? 32'($urandom) : cm_data;
            o.valid = cm_rand ? ($urandom_range(0, 3) != 0) : cm_valid;
            op_q.push_back(o);
            pend     <= o;
            cm_ready <= 1'b0;
            cm_cnt   <= cm_delay;
        end else if (cm_cnt == 1) begin
            cm_cnt             <= 0;
            cm_ready           <= 1'b1;
            bus.core_valid     <= pend.valid;
            bus.core_read_data <= pend.rdata;
        end else if (cm_cnt > 1) begin
            cm_cnt <= cm_cnt - 1;
        end
    end

    // Ack monitor, sampled mid-cycle.
    ack_t ack_q[$];
    int   dual_ack  = 0;
    int   dual_op   = 0;
    int   stray_err = 0;

    always @(negedge clk) begin
        if (bus.a_ack && bus.b_ack) dual_ack++;
        if (bus.core_read_op && bus.core_write_op) dual_op++;
        if ((bus.a_err && !bus.a_ack) || (bus.b_err && !bus.b_ack)) stray_err++;
        if (bus.a_ack) ack_q.push_back('{port: 1'b0, err: bus.a_err, rdata: bus.a_rdata, cyc: cyc});
        if (bus.b_ack) ack_q.push_back('{port: 1'b1, err: bus.b_err, rdata: bus.b_rdata, cyc: cyc});
    end

    // Reference state: which port was served last and what each rdata register should hold.
    bit          exp_last;
    logic [31:0] exp_rdata [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_acked();
        foreach (ack_q[k]) begin
            if (ack_q[k].port) bus.b_req = 1'b0;
            else               bus.a_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
        tick();
        reset        = 1'b0;
        exp_last     = 1'b1;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        op_q.delete();
        ack_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ":a_ack"},  32'(bus.a_ack), 32'h0);
        check({tag, ":b_ack"},  32'(bus.b_ack), 32'h0);
        check({tag, ":a_err"},  32'(bus.a_err), 32'h0);
        check({tag, ":b_err"},  32'(bus.b_err), 32'h0);
        check({tag, ":a_rdata"}, bus.a_rdata, 32'h0);
        check({tag, ":b_rdata"}, bus.b_rdata, 32'h0);
        check({tag, ":wr_op"},  32'(bus.core_write_op), 32'h0);
        check({tag, ":rd_op"},  32'(bus.core_read_op), 32'h0);
        check({tag, ":addr"},   32'(bus.core_addr), 32'h0);
        check({tag, ":wdata"},  bus.core_write_data, 32'h0);
    endtask

    // One round: raise the selected requests, wait for every ack, compare with the model.
    task automatic run_round(input string tag, input bit ra, input bit rb,
                             input bit wa, input bit wb,
                             input logic [10:0] aa, input logic [10:0] ab,
                             input logic [31:0] da, input logic [31:0] db,
                             input int delay);
        int          start;
        int          nreq;
        int          limit;
        bit          order [2];
        bit          pwe;
        logic [10:0] paddr;
        logic [31:0] pdata;
        bit          exp_err;
        int          exp_cyc;
        cm_delay = delay;
        op_q.delete();
        ack_q.delete();
        nreq     = int'(ra) + int'(rb);
        order[0] = (ra && rb) ? !exp_last : rb;
        order[1] = !order[0];
        bus.a_we = wa; bus.a_addr = aa; bus.a_wdata = da; bus.a_req = ra;
        bus.b_we = wb; bus.b_addr = ab; bus.b_wdata = db; bus.b_req = rb;
        start = cyc;
        limit = 0;
        while (ack_q.size() < nreq && limit < 400) begin
            tick();
            limit++;
            drop_acked();
        end
        check({tag, ":completed"}, 32'(limit < 400), 32'h1);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        repeat (3) tick();
        check({tag, ":acks"}, 32'(ack_q.size()), 32'(nreq));
        check({tag, ":ops"},  32'(op_q.size()),  32'(nreq));
        for (int i = 0; i < nreq && i < ack_q.size() && i < op_q.size(); i++) begin
            pwe   = order[i] ? wb : wa;
            paddr = order[i] ? ab : aa;
            pdata = order[i] ? db : da;
            check({tag, ":port"},    32'(ack_q[i].port), 32'(order[i]));
            check({tag, ":op_we"},   32'(op_q[i].we),    32'(pwe));
            check({tag, ":op_addr"}, 32'(op_q[i].addr),  32'(paddr));
            if (pwe) check({tag, ":op_wdata"}, op_q[i].wdata, pdata);
            exp_err = pwe ? 1'b0 : !op_q[i].valid;
            if (!pwe) exp_rdata[order[i]] = op_q[i].rdata;
            check({tag, ":err"},   32'(ack_q[i].err), 32'(exp_err));
            check({tag, ":rdata"}, ack_q[i].rdata, exp_rdata[order[i]]);
            // req edge, ISSUE, WAIT_START, delay low cycles, ready seen -> DONE
            exp_cyc = (i == 0) ? start + delay + 3 : ack_q[0].cyc + delay + 4;
            check({tag, ":latency"}, 32'(ack_q[i].cyc), 32'(exp_cyc));
        end
        if (nreq > 0) exp_last = order[nreq-1];
        check({tag, ":a_rdata_hold"}, bus.a_rdata, exp_rdata[0]);
        check({tag, ":b_rdata_hold"}, bus.b_rdata, exp_rdata[1]);
    endtask

    initial begin
        int          limit;
        int          start;
        bit          ra, rb;
        logic [31:0] da, db;
        reset = 1'b1;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

        // Reset state
        do_reset();
        check_zero_outputs("reset");

        // Single read, core busy for 10 cycles
        cm_rand = 1'b0; cm_data = 32'hDEADBEEF; cm_valid = 1'b1;
        run_round("single_rd", 1'b1, 1'b0, 1'b0, 1'b0, 11'h123, 11'h0,
                  32'h0, 32'h0, 10);
        if (op_q.size() > 0) check("single_rd:core_addr", 32'(op_q[0].addr), 32'h123);
        check("single_rd:a_rdata", bus.a_rdata, 32'hDEADBEEF);
        check("single_rd:b_rdata", bus.b_rdata, 32'h0);

        // Tie round-robin from reset with both requests held high
        do_reset();
        cm_delay = 2;
        da = 32'h1111_A5A5; db = 32'h2222_5A5A;
        bus.a_we = 1'b1; bus.a_addr = 11'h010; bus.a_wdata = da; bus.a_req = 1'b1;
        bus.b_we = 1'b1; bus.b_addr = 11'h020; bus.b_wdata = db; bus.b_req = 1'b1;
        limit = 0;
        while (ack_q.size() < 4 && limit < 200) begin
            tick();
            limit++;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        repeat (6) tick();
        check("tie:acks", 32'(ack_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_q.size() && i < op_q.size(); i++) begin
            check("tie:port",  32'(ack_q[i].port), 32'(i % 2));
            check("tie:wdata", op_q[i].wdata, (i % 2 == 1) ? db : da);
            check("tie:we",    32'(op_q[i].we), 32'h1);
        end
        exp_last = 1'b1;
        check("tie:dual_ack", 32'(dual_ack), 32'h0);

        // Init stall: core not ready for 200 cycles after reset
        do_reset();
        hold_low = 1'b1;
        cm_delay = 3;
        bus.a_we = 1'b0; bus.a_addr = 11'h055; bus.a_req = 1'b1;
        repeat (200) tick();
        check("stall:no_op",  32'(op_q.size()),  32'h0);
        check("stall:no_ack", 32'(ack_q.size()), 32'h0);
        hold_low = 1'b0;
        start = cyc;
        limit = 0;
        while (ack_q.size() < 1 && limit < 100) begin
            tick();
            limit++;
            drop_acked();
        end
        repeat (2) tick();
        check("stall:acks", 32'(ack_q.size()), 32'h1);
        if (ack_q.size() > 0) begin
            check("stall:latency", 32'(ack_q[0].cyc), 32'(start + 3 + 3));
            check("stall:rdata",   ack_q[0].rdata, 32'hDEADBEEF);
        end
        exp_rdata[0] = 32'hDEADBEEF;
        exp_last     = 1'b0;

        // Read error on port B
        cm_data = 32'hCAFE_0042; cm_valid = 1'b0;
        run_round("rd_err", 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 11'h7FF,
                  32'h0, 32'h0, 4);
        check("rd_err:b_rdata", bus.b_rdata, 32'hCAFE_0042);
        if (ack_q.size() > 0) check("rd_err:b_err", 32'(ack_q[0].err), 32'h1);

        // Randomized rounds
        cm_rand = 1'b1;
        for (int r = 0; r < 24; r++) begin
            ra = 1'($urandom);
            rb = 1'($urandom);
            if (!ra && !rb) ra = 1'b1;
            run_round("rand", ra, rb, 1'($urandom), 1'($urandom),
                      11'($urandom), 11'($urandom), 32'($urandom), 32'($urandom),
                      int'($urandom_range(1, 8)));
        end
        check("rand:dual_op", 32'(dual_op), 32'h0);

        // Reset in WAIT_DONE
        run_round("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 11'h321, 11'h0,
                  32'h0, 32'h0, 2);
        cm_delay = 10;
        ack_q.delete();
        bus.a_we = 1'b0; bus.a_addr = 11'h0AB; bus.a_req = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_zero_outputs("mid_rst");
        reset     = 1'b0;
        bus.a_req = 1'b0;
        exp_last     = 1'b1;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        repeat (15) tick();
        check("mid_rst:no_ack", 32'(ack_q.size()), 32'h0);
        run_round("post_rst", 1'b1, 1'b1, 1'b1, 1'b0, 11'h111, 11'h222,
                  32'h0BAD_F00D, 32'h0, 3);

`ifdef MKMIF_ARB_TIMEOUT_EN
        // Watchdog: core never returns ready after the command
        run_round("pre_tmo", 1'b1, 1'b0, 1'b0, 1'b0, 11'h044, 11'h0,
                  32'h0, 32'h0, 2);
        cm_delay = 1000;
        ack_q.delete();
        op_q.delete();
        bus.a_we = 1'b0; bus.a_addr = 11'h066; bus.a_req = 1'b1;
        start = cyc;
        limit = 0;
        while (ack_q.size() < 1 && limit < 100) begin
            tick();
            limit++;
            drop_acked();
        end
        repeat (2) tick();
        check("tmo:acks", 32'(ack_q.size()), 32'h1);
        if (ack_q.size() > 0) begin
            // grant, one ISSUE cycle, then TMO waiting cycles before DONE
            check("tmo:latency", 32'(ack_q[0].cyc), 32'(start + 2 + int'(TMO)));
            check("tmo:err",     32'(ack_q[0].err), 32'h1);
        end
        check("tmo:a_rdata", bus.a_rdata, exp_rdata[0]);
        do_reset();
`endif

        check("end:dual_ack",  32'(dual_ack),  32'h0);
        check("end:stray_err", 32'(stray_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
